// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM read-stream requester: FSM state
// encoding and the SDRAM data-bus width.
package sdram_pkg;

  localparam int SDRAM_DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2
  } rd_state_e;

endpackage

// File: rtl/sdram_rd_ctrl.sv
// sdram_rd_ctrl: requests fixed-length SDRAM read bursts while the rfifo has
// room, forwards returned words into the rfifo and walks a wrapping read
// address over [rd_base_addr, rd_end_addr].
// Optional feature macro: RD_TIMEOUT_EN (DATA-state watchdog, drives tmo_err).
module sdram_rd_ctrl
  import sdram_pkg::*;
#(
  parameter int ADDR_W     = 22,
  parameter int BURST_LEN  = 8,
  parameter int USEDW_W    = 10,
  parameter int FIFO_DEPTH = 512,
  parameter int TMO_CYC    = 64
) (
  input  logic                sdram_clk,
  input  logic                rst,
  input  logic                rd_en,
  input  logic                rd_addr_load,
  input  logic [ADDR_W-1:0]   rd_base_addr,
  input  logic [ADDR_W-1:0]   rd_end_addr,
  input  logic [USEDW_W-1:0]  fifo_usedw,
  input  logic                fifo_full,
  output logic                rd_req,
  input  logic                rd_ack,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic                sdram_rd_vld,
  input  logic [SDRAM_DW-1:0] sdram_rd_data,
  output logic                fifo_wr_en,
  output logic [SDRAM_DW-1:0] fifo_wr_data,
  output logic                busy,
  output logic                ovf_err,
  output logic                tmo_err
);

  localparam int                 CNT_W    = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [USEDW_W:0]   DEPTH_X  = (USEDW_W + 1)'(FIFO_DEPTH);
  localparam logic [USEDW_W:0]   BURST_X  = (USEDW_W + 1)'(BURST_LEN);
  localparam logic [ADDR_W-1:0]  ADDR_INC = ADDR_W'(BURST_LEN);

  rd_state_e             state_q, state_d;
  logic [ADDR_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pend_q, pend_d;
  logic                  rd_req_q, rd_req_d;
  logic                  busy_q, busy_d;
  logic                  wr_en_q, wr_en_d;
  logic [SDRAM_DW-1:0]   wr_data_q, wr_data_d;
  logic                  ovf_q, ovf_d;

  logic [USEDW_W:0]      usedw_x_s;
  logic [USEDW_W:0]      room_s;
  logic                  space_ok_s;
  logic [ADDR_W-1:0]     ptr_next_s;

`ifdef RD_TIMEOUT_EN
  localparam int               WDOG_W    = $clog2(TMO_CYC) + 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TMO_CYC - 1);
  logic [WDOG_W-1:0]     wdog_q, wdog_d;
  logic                  tmo_q, tmo_d;
`endif

  // Room test at USEDW_W+1 bits; a fill above the depth simply means no room.
  always_comb begin
    usedw_x_s  = {1'b0, fifo_usedw};
    room_s     = DEPTH_X - usedw_x_s;
    space_ok_s = 1'b0;
    if (usedw_x_s <= DEPTH_X) begin
      space_ok_s = (room_s >= BURST_X);
    end else begin
      space_ok_s = 1'b0;
    end
  end

  // Pointer value taken at burst end: a pending/coincident load wins over wrap/advance.
  always_comb begin
    ptr_next_s = ptr_q + ADDR_INC;
    if (pend_q || rd_addr_load) begin
      ptr_next_s = rd_base_addr;
    end else if (ptr_q == rd_end_addr) begin
      ptr_next_s = rd_base_addr;
    end else begin
      ptr_next_s = ptr_q + ADDR_INC;
    end
  end

  // Next-state and next-output computation for the request/data FSM.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    ovf_d     = ovf_q | (sdram_rd_vld & fifo_full);
`ifdef RD_TIMEOUT_EN
    wdog_d    = wdog_q;
    tmo_d     = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        pend_d = 1'b0;
        if (rd_addr_load) begin
          ptr_d = rd_base_addr;
        end else if (rd_en && space_ok_s) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (rd_addr_load) begin
          pend_d = 1'b1;
        end else begin
          pend_d = pend_q;
        end
        if (rd_ack) begin
          state_d = ST_DATA;
          cnt_d   = '0;
`ifdef RD_TIMEOUT_EN
          wdog_d  = '0;
`endif
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_DATA: begin
        if (rd_addr_load) begin
          pend_d = 1'b1;
        end else begin
          pend_d = pend_q;
        end
        if (sdram_rd_vld) begin
          wr_en_d   = 1'b1;
          wr_data_d = sdram_rd_data;
          cnt_d     = cnt_q + CNT_W'(1);
`ifdef RD_TIMEOUT_EN
          wdog_d    = '0;
`endif
          if (cnt_q == CNT_LAST) begin
            ptr_d   = ptr_next_s;
            pend_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
          end
`ifdef RD_TIMEOUT_EN
        end else if (wdog_q == WDOG_LAST) begin
          // Abandon the burst without advancing; IDLE re-requests the same address.
          tmo_d   = 1'b1;
          wdog_d  = '0;
          state_d = ST_IDLE;
        end else begin
          wdog_d  = wdog_q + WDOG_W'(1);
          state_d = ST_DATA;
`else
        end else begin
          state_d = ST_DATA;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    rd_req_d = (state_d == ST_REQ);
    busy_d   = (state_d != ST_IDLE);
  end

  // State, datapath and registered outputs with synchronous reset.
  always_ff @(posedge sdram_clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      rd_req_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      rd_req_q  <= rd_req_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef RD_TIMEOUT_EN
  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge sdram_clk) begin
    if (rst) begin
      wdog_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      tmo_q  <= tmo_d;
    end
  end

  assign tmo_err = tmo_q;
`else
  assign tmo_err = 1'b0;
`endif

  assign rd_req       = rd_req_q;
  assign rd_addr      = ptr_q;
  assign busy         = busy_q;
  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = wr_data_q;
  assign ovf_err      = ovf_q;

endmodule

// File: tb/tb_sdram_rd_ctrl.sv
// Scoreboard bench for sdram_rd_ctrl: stimulus pushes expected burst
// addresses and fifo words into queues; a negedge monitor pops and compares.
// Build with +define+RD_TIMEOUT_EN to exercise the watchdog variant.
module tb_sdram_rd_ctrl;

  localparam int ADDR_W    = 22;
  localparam int BURST_LEN = 8;
  localparam int TMO_CYC   = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              rd_en;
  logic              rd_addr_load;
  logic [ADDR_W-1:0] rd_base_addr;
  logic [ADDR_W-1:0] rd_end_addr;
  logic [9:0]        fifo_usedw;
  logic              fifo_full;
  logic              rd_req;
  logic              rd_ack;
  logic [ADDR_W-1:0] rd_addr;
  logic              sdram_rd_vld;
  logic [15:0]       sdram_rd_data;
  logic              fifo_wr_en;
  logic [15:0]       fifo_wr_data;
  logic              busy;
  logic              ovf_err;
  logic              tmo_err;

  int checks = 0;
  int errors = 0;
  logic [ADDR_W-1:0] addr_q[$];
  logic [15:0]       data_q[$];
  logic              req_prev = 1'b0;

  always #5 clk = ~clk;

  sdram_rd_ctrl dut (
    .sdram_clk    (clk),
    .rst          (rst),
    .rd_en        (rd_en),
    .rd_addr_load (rd_addr_load),
    .rd_base_addr (rd_base_addr),
    .rd_end_addr  (rd_end_addr),
    .fifo_usedw   (fifo_usedw),
    .fifo_full    (fifo_full),
    .rd_req       (rd_req),
    .rd_ack       (rd_ack),
    .rd_addr      (rd_addr),
    .sdram_rd_vld (sdram_rd_vld),
    .sdram_rd_data(sdram_rd_data),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .busy         (busy),
    .ovf_err      (ovf_err),
    .tmo_err      (tmo_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every fifo write and every new burst request against the queues.
  always @(negedge clk) begin
    if (fifo_wr_en === 1'b1) begin
      if (data_q.size() == 0) begin
        check("wr_unexpected", 64'(fifo_wr_data), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        check("wr_data", 64'(fifo_wr_data), 64'(data_q.pop_front()));
      end
    end
    if (rd_req === 1'b1 && req_prev === 1'b0) begin
      if (addr_q.size() == 0) begin
        check("req_unexpected", 64'(rd_addr), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        check("rd_addr", 64'(rd_addr), 64'(addr_q.pop_front()));
      end
    end
    req_prev = rd_req;
  end

  // One burst: optional address expectation, ack, then nwords returned words.
  task automatic run_burst(input logic push_addr, input logic [ADDR_W-1:0] exp_addr,
                           input int nwords, input logic [15:0] dbase,
                           input int full_idx, input int load_idx);
    int k;
    if (push_addr) addr_q.push_back(exp_addr);
    rd_en = 1'b1;
    k = 0;
    while (rd_req !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (rd_req !== 1'b1) begin
      check("req_timeout", 64'(rd_req), 64'd1);
      return;
    end
    rd_ack = 1'b1;
    rd_en  = 1'b0;
    @(posedge clk); #1;
    rd_ack = 1'b0;
    for (int i = 0; i < nwords; i++) begin
      sdram_rd_vld  = 1'b1;
      sdram_rd_data = dbase + 16'(i);
      fifo_full     = (i == full_idx);
      rd_addr_load  = (i == load_idx);
      data_q.push_back(dbase + 16'(i));
      @(posedge clk); #1;
      if (i == BURST_LEN - 2) check("busy_mid", 64'(busy), 64'd1);
    end
    sdram_rd_vld = 1'b0;
    fifo_full    = 1'b0;
    rd_addr_load = 1'b0;
    if (nwords == BURST_LEN) begin
      @(negedge clk);
      check("burst_end_idle", 64'(busy), 64'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b1; rd_en = 1'b1; rd_addr_load = 1'b0;
    rd_base_addr = '0; rd_end_addr = 22'h108;
    fifo_usedw = 10'd0; fifo_full = 1'b0; rd_ack = 1'b0;
    sdram_rd_vld = 1'b0; sdram_rd_data = 16'h0000;

    // 1. reset holds everything at zero, request rises quickly after release
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {rd_req, 22'(rd_addr), fifo_wr_en, fifo_wr_data, busy, ovf_err, tmo_err}, 64'd0);
    addr_q.push_back(22'h000);
    @(posedge clk); #1;
    rst = 1'b0;
    k = 0;
    while (rd_req !== 1'b1 && k < 2) begin
      @(posedge clk); #1;
      k++;
    end
    check("req_after_reset", 64'(rd_req), 64'd1);
    run_burst(1'b0, 22'h000, BURST_LEN, 16'h1000, -1, -1);

    // 2. load base in IDLE, then three wrapping bursts
    rd_base_addr = 22'h100;
    rd_addr_load = 1'b1;
    @(posedge clk); #1;
    rd_addr_load = 1'b0;
    run_burst(1'b1, 22'h100, BURST_LEN, 16'h2000, -1, -1);
    run_burst(1'b1, 22'h108, BURST_LEN, 16'h2100, -1, -1);
    run_burst(1'b1, 22'h100, BURST_LEN, 16'h2200, -1, -1);

    // 3. space test boundary: 7 free words blocks, 8 free words requests
    fifo_usedw = 10'd505;
    rd_en = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("no_req_space7", {rd_req, busy}, 64'd0);
    @(posedge clk); #1;
    fifo_usedw = 10'd504;
    run_burst(1'b1, 22'h108, BURST_LEN, 16'h3000, -1, -1);
    fifo_usedw = 10'd0;

    // 4. stray words in IDLE are dropped; overflow flag is sticky
    sdram_rd_vld = 1'b1; sdram_rd_data = 16'hDEAD;
    @(negedge clk);
    check("stray_no_wr0", 64'(fifo_wr_en), 64'd0);
    @(negedge clk);
    check("stray_no_wr1", 64'(fifo_wr_en), 64'd0);
    @(posedge clk); #1;
    sdram_rd_vld = 1'b0;
    @(negedge clk);
    check("ovf_clear", 64'(ovf_err), 64'd0);
    run_burst(1'b1, 22'h100, BURST_LEN, 16'h4000, 2, -1);
    check("ovf_set", 64'(ovf_err), 64'd1);
    repeat (5) @(posedge clk);
    #1 check("ovf_sticky", 64'(ovf_err), 64'd1);

    // 5. load pulsed mid-burst replaces the normal advance
    rd_base_addr = 22'h200;
    run_burst(1'b1, 22'h108, BURST_LEN, 16'h5000, -1, 4);
    run_burst(1'b1, 22'h200, BURST_LEN, 16'h5100, -1, -1);

    // 6. silence after 3 words
    run_burst(1'b1, 22'h208, 3, 16'h6000, -1, -1);
`ifdef RD_TIMEOUT_EN
    repeat (TMO_CYC - 1) @(posedge clk);
    #1;
    check("tmo_not_yet", {tmo_err, busy}, 64'd1);
    @(posedge clk); #1;
    check("tmo_fired", {tmo_err, busy}, 64'd2);
    run_burst(1'b1, 22'h208, BURST_LEN, 16'h6100, -1, -1);
    check("tmo_sticky", 64'(tmo_err), 64'd1);
`else
    repeat (100) @(posedge clk);
    #1;
    check("data_waits", {tmo_err, busy}, 64'd1);
    for (int i = 3; i < BURST_LEN; i++) begin
      sdram_rd_vld  = 1'b1;
      sdram_rd_data = 16'h6000 + 16'(i);
      data_q.push_back(16'h6000 + 16'(i));
      @(posedge clk); #1;
    end
    sdram_rd_vld = 1'b0;
    @(negedge clk);
    check("late_burst_end", 64'(busy), 64'd0);
`endif

    repeat (4) @(posedge clk);
    check("data_q_empty", 64'(data_q.size()), 64'd0);
    check("addr_q_empty", 64'(addr_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
